// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, datapath widths and store-buffer sizing.
// Consumed by wb_stage and wb_store_fifo.
package pipe_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LDO   = 3'b001;
    localparam logic [2:0] OP_LDA   = 3'b010;
    localparam logic [2:0] OP_STO   = 3'b011;
    localparam logic [2:0] OP_ACC_A = 3'b100;
    localparam logic [2:0] OP_ACC_B = 3'b101;
    localparam logic [2:0] OP_ALU   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int REG_W       = 8;
    localparam int REG_ADDR_W  = 5;
    localparam int NUM_REGS    = 1 << REG_ADDR_W;
    localparam int STBUF_DEPTH = 2;

    // Opcodes that retire through the register file.
    function automatic logic is_reg_op(input logic [2:0] op);
        return (op == OP_LDO) || (op == OP_LDA) || (op == OP_ALU);
    endfunction

    function automatic logic is_acc_op(input logic [2:0] op);
        return (op == OP_ACC_A) || (op == OP_ACC_B);
    endfunction

endpackage

// File: rtl/wb_store_fifo.sv
// Store buffer holding {addr, data} pairs until the data memory accepts them.
// Head data reads as zero while the buffer is empty.
module wb_store_fifo
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [2*REG_W-1:0]   i_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [2*REG_W-1:0]   o_head_data
);
    localparam int PTR_W = $clog2(STBUF_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [2*REG_W-1:0] r_mem [STBUF_DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

    assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: register file, accumulator, buffered stores and sticky halt.
// Define WB_BYPASS_EN to forward a same-cycle register write onto the read ports.
module wb_stage
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            in_wb_opcode,
    input  logic                  in_reg_write,
    input  logic                  in_mem_write,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [REG_W-1:0]      in_imm,
    input  logic [REG_W-1:0]      in_reg_data,
    input  logic [REG_W-1:0]      in_acc_data,
    input  logic [REG_W-1:0]      in_mem_data,
    input  logic [REG_ADDR_W-1:0] rf_raddr_a,
    input  logic [REG_ADDR_W-1:0] rf_raddr_b,
    output logic [REG_W-1:0]      rf_rdata_a,
    output logic [REG_W-1:0]      rf_rdata_b,
    output logic [REG_W-1:0]      acc_out,
    output logic                  dmem_req,
    output logic [REG_W-1:0]      dmem_addr,
    output logic [REG_W-1:0]      dmem_wdata,
    input  logic                  dmem_ack,
    output logic                  stall,
    output logic                  halted
);
    logic [REG_W-1:0]   r_regs [NUM_REGS];
    logic [REG_W-1:0]   r_acc;
    logic               r_halted;
    logic               w_is_sto;
    logic               w_commit_ok;
    logic               w_reg_we;
    logic               w_acc_we;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [2*REG_W-1:0] w_head;
    logic [REG_W-1:0]   w_stored_a;
    logic [REG_W-1:0]   w_stored_b;

    // dmem handshake: req stays high with addr/wdata frozen on the head entry;
    // the transfer completes on the cycle where req and ack are both high.
    assign w_is_sto     = in_mem_write && (in_wb_opcode == OP_STO);
    assign stall        = w_fifo_full && w_is_sto && !dmem_ack;
    assign w_commit_ok  = rst && !stall && !r_halted;
    assign w_reg_we     = w_commit_ok && in_reg_write && is_reg_op(in_wb_opcode) &&
                          (in_dest != '0);
    assign w_acc_we     = w_commit_ok && is_acc_op(in_wb_opcode);
    assign w_push       = w_commit_ok && w_is_sto;
    assign w_pop        = dmem_req && dmem_ack;

    wb_store_fifo u_store_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_data      ({in_imm, in_mem_data}),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head_data (w_head)
    );

    assign dmem_req   = !w_fifo_empty;
    assign dmem_addr  = w_head[2*REG_W-1:REG_W];
    assign dmem_wdata = w_head[REG_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_reg_we) begin
            r_regs[in_dest] <= in_reg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc    <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_acc_we) r_acc <= in_acc_data;
            if (in_wb_opcode == OP_HALT) r_halted <= 1'b1;
        end
    end

    assign acc_out = r_acc;
    assign halted  = r_halted;

    assign w_stored_a = (rf_raddr_a == '0) ? '0 : r_regs[rf_raddr_a];
    assign w_stored_b = (rf_raddr_b == '0) ? '0 : r_regs[rf_raddr_b];

`ifdef WB_BYPASS_EN
    // w_reg_we already excludes register 0, so no separate zero check here.
    assign rf_rdata_a = (w_reg_we && (rf_raddr_a == in_dest)) ? in_reg_data : w_stored_a;
    assign rf_rdata_b = (w_reg_we && (rf_raddr_b == in_dest)) ? in_reg_data : w_stored_b;
`else
    assign rf_rdata_a = w_stored_a;
    assign rf_rdata_b = w_stored_b;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have ports: in_wb_opcode  in  3, plus in_reg_write and in_mem_write  in  1 each; control from the MEM stage.
REQ-004 SHALL have ports: in_dest  in  5  target register; in_imm  in  8  store address.
REQ-005 SHALL have ports: in_reg_data, in_acc_data, in_mem_data  in  8 each; write values from the MEM stage.
REQ-006 SHALL have ports: rf_raddr_a and rf_raddr_b  in  5; rf_rdata_a and rf_rdata_b  out  8; decode read ports.
REQ-007 SHALL have ports: acc_out  out  8  accumulator value.
REQ-008 SHALL have ports: dmem_req  out  1; dmem_addr  out  8; dmem_wdata  out  8; dmem_ack  in  1.
REQ-009 SHALL have ports: stall  out  1  hold upstream; halted  out  1  sticky halt flag.

Function
REQ-010 SHALL decode opcodes 000 NOP, 001 LDO, 010 LDA, 110 ALU-to-reg, 011 STO, 100/101 ACC update, 111 HALT.
REQ-011 SHALL write in_reg_data to regfile[in_dest] at the clock edge when in_reg_write=1, opcode is 001, 010 or 110, stall=0 and halted=0.
REQ-012 SHALL keep register 0 at 0 and ignore all writes to it.
REQ-013 SHALL load in_acc_data into ACC at the clock edge when opcode is 100 or 101, stall=0 and halted=0.
REQ-014 SHALL push {in_imm, in_mem_data} into a 2-entry store FIFO when in_mem_write=1, opcode=011, stall=0 and halted=0.
REQ-015 SHALL drive dmem_req=1 while the FIFO is non-empty, with dmem_addr and dmem_wdata taken from the head entry; these outputs are held stable until dmem_ack.
REQ-016 SHALL pop the FIFO head on a cycle with dmem_req=1 and dmem_ack=1; dmem_ack while dmem_req=0 is ignored.
REQ-017 SHALL compute stall = FIFO full AND incoming STO (in_mem_write=1, opcode=011) AND NOT dmem_ack, combinationally; a simultaneous pop and push on a full FIFO is accepted with no stall.
REQ-018 SHALL commit nothing for an instruction presented while stall=1; upstream holds the inputs until stall=0.
REQ-019 SHALL set halted=1 at the clock edge after opcode 111 is presented, and hold it until reset.
REQ-020 SHALL suppress all commits while halted=1, but SHALL continue draining the FIFO.
REQ-021 SHALL return regfile[rf_raddr_x] combinationally on rf_rdata_x, with reads of address 0 returning 0.
REQ-022 SHALL treat combinations that do not match REQ-011/013/014 (e.g. in_reg_write=1 with opcode 011) as NOP.

Reset
REQ-023 SHALL, on a clock edge with rst=0, clear all 32 registers, ACC, both FIFO pointers and halted.
REQ-024 SHALL drive acc_out=0, dmem_req=0, dmem_addr=0, dmem_wdata=0, stall=0 and halted=0 from the reset edge on.
REQ-025 SHALL discard pending FIFO entries on reset mid-transaction, without waiting for dmem_ack.

Configuration
REQ-026 SHALL, with WB_BYPASS_EN defined, forward a same-cycle committing write (REQ-011) on rf_rdata_x when rf_raddr_x equals in_dest and is nonzero.
REQ-027 SHALL, without WB_BYPASS_EN defined, return only the stored value, so the new value is visible one cycle after the write.

Structure
REQ-028 SHALL take opcode localparams (OP_NOP to OP_HALT), REG_W=8, REG_ADDR_W=5 and STBUF_DEPTH=2 from shared package pipe_pkg.
REQ-029 SHALL implement the store FIFO as sub-module wb_store_fifo, with push, pop, full, empty and head data ports.

Verification
REQ-030 SHALL cover: opcode 110, dest=5, reg_data=0x3C -> next cycle rf_rdata_a=0x3C with raddr_a=5; same cycle 0x3C only with WB_BYPASS_EN.
REQ-031 SHALL cover: opcode 001 to dest=0 with data 0xFF -> rf_rdata of address 0 stays 0x00.
REQ-032 SHALL cover: three back-to-back STO (addr 0x10, 0x11, 0x12) with dmem_ack=0 -> third cycle stall=1; one ack cycle -> stall=0, third store accepted, addr 0x10 drained first.
REQ-033 SHALL cover: opcode 100 with acc_data=0xA5, then opcode 101 with 0x5A -> acc_out 0xA5, then 0x5A on consecutive cycles.
REQ-034 SHALL cover: HALT followed by opcode 110, dest=3, data 0x77 -> halted=1, reg 3 unchanged, pending store still drained on ack.
REQ-035 SHALL cover: rst=0 with two FIFO entries pending and ACC=0x12 -> next edge dmem_req=0, acc_out=0, halted=0, all registers read 0.
